demux1to4_buf: RTL
==================

Name: demux1to4_buf

Overview:
- Write-side counterpart of the datapath's 16-bit 4:1 select mux.
- Takes one WIDTH-bit word with a 2-bit select and routes it to one of four destination channels (y0..y3).
- Each channel has a one-entry holding register and a valid/ready handshake, so downstream stages can stall independently.
- Used to fan a single pipeline result out to four consumers (register-file write ports / forwarding sinks).

Parameters:
- WIDTH, 16, data width of the input and of each output channel.
- CNT_W, 8, width of each per-channel delivered-word counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- sel  input  2  destination channel of the input word (0..3).
- d  input  WIDTH  input data word.
- d_valid  input  1  input word present.
- d_ready  output  1  block accepts input this cycle.
- y0, y1, y2, y3  output  WIDTH each  channel holding-register contents.
- y_valid  output  4  bit k = channel k holds an undelivered word.
- y_ready  input  4  bit k = consumer k accepts the word this cycle.
- cnt0, cnt1, cnt2, cnt3  output  CNT_W each  words delivered on channel k (count of y_valid[k] & y_ready[k]).
- idle  output  1  high when y_valid == 4'b0000.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-low (clk, rst_n).
- Reset values when rst_n=0 at a clock edge: y0..y3=0, y_valid=0, cnt0..cnt3=0. idle is combinational and therefore reads 1 after reset.
- Reset mid-operation: held words are discarded with no delivery and no count. The rst_n=0 edge overrides any load or drain in that cycle.
- d_ready (combinational) = ~y_valid[sel] | y_ready[sel]. It depends only on the selected channel; other channels' stalls do not block input.
- Load: on an edge with d_valid & d_ready, the channel's register y[sel] takes d and y_valid[sel] is set to 1.
  - Latency: 1 cycle from accept to y_valid.
  - d must not pass combinationally to any y.
- Drain: on an edge with y_valid[k] & y_ready[k]:
  - cnt_k increments by 1, wrapping from 2^CNT_W-1 to 0.
  - y_valid[k] clears to 0, unless channel k is loaded on the same edge.
- Simultaneous load and drain, same channel: the new word replaces the old one, y_valid stays 1 and cnt increments. This gives full throughput of 1 word/cycle per channel.
- Simultaneous load on channel j and drains on other channels: all are independent and all take effect on that edge.
- No load when d_valid=0, even if d_ready=1. d and sel are don't-care when d_valid=0.
- Full channel with consumer stalled (y_valid[sel]=1, y_ready[sel]=0):
  - d_ready=0 and the word is not accepted.
  - The producer holds d, sel and d_valid stable.
  - y[sel] is unchanged.
- y_ready[k] while y_valid[k]=0 has no effect, and the counter does not change.
- y0..y3 hold their last value after drain; they are only meaningful while y_valid is set.
- idle = ~|y_valid (combinational).

Test Plan:
- Reset: drive rst_n=0 for 2 cycles with d_valid=1, sel=2, d=95 -> y_valid=0000, all y=0, all cnt=0, idle=1. Release -> the word (95) loads on the first edge after release.
- Routing, one word per channel with y_ready=1111: (sel,d) = (0,20), (1,70), (2,1), (3,13) on consecutive cycles -> each y_k shows its word one cycle after accept, each y_valid bit pulses for 1 cycle, d_ready stays 1, final cnt0..cnt3 = 1,1,1,1.
- Backpressure:
  - y_ready=0000, load sel=1 d=60 -> y_valid=0010, y1=60, d_ready=0 while sel=1.
  - Present sel=1 d=80 for 3 cycles -> y1 stays 60, cnt1=0.
  - Meanwhile present sel=3 d=39 -> accepted, y_valid=1010.
  - Raise y_ready[1] -> 60 delivered, 80 loads on that same edge, cnt1=1.
- Throughput on channel 2 with y_ready[2]=1: stream d=40, 50, 90, 100 back-to-back -> accepted 1 per cycle, y2 sequence 40, 50, 90, 100, y_valid[2] held high throughout, cnt2=4.
- Counter wrap, CNT_W=8: 256 delivered words on channel 0 -> cnt0 reads 255 then 0.
- Reset mid-operation: with y_valid=1111 and y_ready=0000, pulse rst_n=0 for 1 cycle while d_valid=1 -> y_valid=0000, no cnt change beyond clearing to 0, idle=1.

Source files
------------

// File: rtl/demux1to4_buf_if.sv
// Bus bundle for the 1:4 buffered demux: one input word with select, four held output channels.
// The slave view is the demux itself; the master view is the producer/consumer side.
interface demux1to4_buf_if #(
   parameter int WIDTH = 16
);
   logic [1:0]       sel;
   logic [WIDTH-1:0] d;
   logic             d_valid;
   logic             d_ready;
   logic [WIDTH-1:0] y0;
   logic [WIDTH-1:0] y1;
   logic [WIDTH-1:0] y2;
   logic [WIDTH-1:0] y3;
   logic [3:0]       y_valid;
   logic [3:0]       y_ready;

   modport slave (
      input  sel, d, d_valid, y_ready,
      output d_ready, y0, y1, y2, y3, y_valid
   );

   modport master (
      output sel, d, d_valid, y_ready,
      input  d_ready, y0, y1, y2, y3, y_valid
   );
endinterface

// File: rtl/demux1to4_buf.sv
// Routes one input word to one of four single-entry channel registers with per-channel valid/ready.
// Latency 1 cycle accept->y_valid; d_ready drops only when the selected channel is full and stalled.
module demux1to4_buf #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   demux1to4_buf_if.slave   bus,
   output logic [CNT_W-1:0] cnt0,
   output logic [CNT_W-1:0] cnt1,
   output logic [CNT_W-1:0] cnt2,
   output logic [CNT_W-1:0] cnt3,
   output logic             idle
);

   logic [WIDTH-1:0] y_q   [4];
   logic [CNT_W-1:0] cnt_q [4];
   logic [3:0]       vld_q;
   logic [3:0]       load_oh;
   logic [3:0]       drain;
   logic             rdy;

   // Only the targeted channel can block; stalls elsewhere never throttle the producer.
   assign rdy     = ~vld_q[bus.sel] | bus.y_ready[bus.sel];
   assign load_oh = (bus.d_valid && rdy) ? (4'b0001 << bus.sel) : 4'b0000;
   assign drain   = vld_q & bus.y_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_q <= 4'b0000;
         for (int k = 0; k < 4; k++) begin
            y_q[k]   <= '0;
            cnt_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < 4; k++) begin
            if (load_oh[k]) begin
               y_q[k] <= bus.d;
            end
            if (drain[k]) begin
               cnt_q[k] <= cnt_q[k] + CNT_W'(1);
            end
            // A same-edge load refills the slot being drained, keeping 1 word/cycle.
            vld_q[k] <= load_oh[k] | (vld_q[k] & ~drain[k]);
         end
      end
   end

   assign bus.d_ready = rdy;
   assign bus.y0      = y_q[0];
   assign bus.y1      = y_q[1];
   assign bus.y2      = y_q[2];
   assign bus.y3      = y_q[3];
   assign bus.y_valid = vld_q;
   assign cnt0        = cnt_q[0];
   assign cnt1        = cnt_q[1];
   assign cnt2        = cnt_q[2];
   assign cnt3        = cnt_q[3];
   assign idle        = ~|vld_q;

endmodule
